// File: rtl/spart_pkg.sv
// Shared SPART definitions: receive FSM states, default oversampling ratio
// and the bus I/O address map used by the bus interface and baud generator.
package spart_pkg;

    // Baud ticks per serial bit time.
    localparam int SPART_OVERSAMPLE = 16;

    // SPART I/O address map (2-bit register select from the bus interface).
    localparam logic [1:0] SPART_ADDR_DATA     = 2'b00;
    localparam logic [1:0] SPART_ADDR_STATUS   = 2'b01;
    localparam logic [1:0] SPART_ADDR_DIV_LOW  = 2'b10;
    localparam logic [1:0] SPART_ADDR_DIV_HIGH = 2'b11;

    // Receive deframer states.
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        BREAK = 3'd4
    } rx_state_t;

endpackage

// File: rtl/sync_2ff.sv
// One-bit two-flop synchronizer for an input that is asynchronous to clk.
// RESET_VAL sets the value both flops take during reset.
module sync_2ff #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    // Two back-to-back flops give the first one a full cycle to resolve metastability.
    // NOTE: sequential state is written with non-blocking assignments so every flop
    // samples the pre-edge value of the others; blocking here would merge the two stages.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/spart_rx.sv
// SPART receive stage: synchronizes the RX line, deframes 8N1 characters on
// oversample ticks and holds the last good character for the bus interface.
module spart_rx
    import spart_pkg::*;
#(
    parameter int OVERSAMPLE = SPART_OVERSAMPLE
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    input  logic       baud_tick,
    input  logic       rx_enable,
    output logic [7:0] rx_data,
    output logic       rda,
    output logic       fe,
    output logic       oe
);

    localparam int CW = $clog2(OVERSAMPLE);
    // Last tick of the first half of the start bit, and last tick of a full bit.
    localparam logic [CW-1:0] CNT_HALF = CW'(OVERSAMPLE / 2 - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(OVERSAMPLE - 1);

    logic            rx_s;
    rx_state_t       state_q;
    logic [CW-1:0]   cnt_q;
    logic [2:0]      bits_q;
    logic [7:0]      shift_q;
    logic [7:0]      data_q;
    logic            rda_q;
    logic            oe_q;
    logic            fe_q;

    // The synchronizer resets to 1 so an idle line never looks like a start bit.
    sync_2ff #(
        .RESET_VAL(1'b1)
    ) u_rx_sync (
        .clk  (clk),
        .rst_n(rst_n),
        .d_i  (rx),
        .q_o  (rx_s)
    );

    // Deframer FSM with registered outputs; line decisions happen only on baud ticks.
    // NOTE: every register, including the shift and holding registers, is cleared by
    // the async reset so an aborted frame leaves nothing behind after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bits_q  <= '0;
            shift_q <= '0;
            data_q  <= '0;
            rda_q   <= 1'b0;
            oe_q    <= 1'b0;
            fe_q    <= 1'b0;
        end else begin
            // Framing error is a single-cycle pulse.
            fe_q <= 1'b0;

            // A CPU read consumes the held character; a load below overrides this.
            if (rx_enable) begin
                rda_q <= 1'b0;
                oe_q  <= 1'b0;
            end

            if (baud_tick) begin
                case (state_q)
                    IDLE: begin
                        if (!rx_s) begin
                            state_q <= START;
                            cnt_q   <= '0;
                        end
                    end

                    START: begin
                        if (rx_s) begin
                            // Line returned high before mid start bit: glitch.
                            state_q <= IDLE;
                        end else if (cnt_q == CNT_HALF) begin
                            state_q <= DATA;
                            cnt_q   <= '0;
                            bits_q  <= '0;
                        end else begin
                            cnt_q <= cnt_q + CW'(1);
                        end
                    end

                    DATA: begin
                        if (cnt_q == CNT_LAST) begin
                            // Centre of a data bit; LSB arrives first.
                            shift_q <= {rx_s, shift_q[7:1]};
                            cnt_q   <= '0;
                            bits_q  <= bits_q + 3'd1;
                            if (bits_q == 3'd7) begin
                                state_q <= STOP;
                            end
                        end else begin
                            cnt_q <= cnt_q + CW'(1);
                        end
                    end

                    STOP: begin
                        if (cnt_q == CNT_LAST) begin
                            cnt_q <= '0;
                            if (rx_s) begin
                                data_q  <= shift_q;
                                rda_q   <= 1'b1;
                                // Overrun if the previous character was still unread,
                                // unless it is being read in this very cycle.
                                oe_q    <= (oe_q | rda_q) & ~rx_enable;
                                state_q <= IDLE;
                            end else begin
                                fe_q    <= 1'b1;
                                state_q <= BREAK;
                            end
                        end else begin
                            cnt_q <= cnt_q + CW'(1);
                        end
                    end

                    BREAK: begin
                        // Hold off until the line idles so a stuck-low line cannot re-trigger.
                        if (rx_s) begin
                            state_q <= IDLE;
                        end
                    end

                    default: begin
                        state_q <= IDLE;
                    end
                endcase
            end
        end
    end

    assign rx_data = data_q;
    assign rda     = rda_q;
    assign fe      = fe_q;
    assign oe      = oe_q;

endmodule

// File: tb/tb_spart_rx.sv
// Self-checking bench for spart_rx: a table of directed 8N1 frames with
// expected results, hand-written corner sequences, and random frames checked
// against a character-level model of the holding register.
module tb_spart_rx;
    import spart_pkg::*;

    // Edges from the cycle the start bit is driven to the edge that sets rda/fe:
    // 2 synchronizer flops + 1 tick to see the low sample + 9.5 bit times (152 ticks).
    localparam int FRAME_LAT = 155;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       rx;
    logic       baud_tick;
    logic       rx_enable;
    logic [7:0] rx_data;
    logic       rda;
    logic       fe;
    logic       oe;

    spart_rx #(
        .OVERSAMPLE(SPART_OVERSAMPLE)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .rx       (rx),
        .baud_tick(baud_tick),
        .rx_enable(rx_enable),
        .rx_data  (rx_data),
        .rda      (rda),
        .fe       (fe),
        .oe       (oe)
    );

    always #5 clk = ~clk;

    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    int   start_cyc = 0;
    int   fe_seen = 0;
    int   fe_cyc = -1;
    int   rda_rise_cyc = -1;
    int   read_at_cyc = -1;
    logic manual_read = 1'b0;
    logic rda_prev = 1'b0;

    // Character-level reference model of the holding register.
    logic [7:0] m_data;
    logic       m_rda;
    logic       m_oe;

    typedef struct {
        logic [7:0] d;
        logic       stop;
        int         extra_low;
        logic       same_read;
        logic       rd_after;
        int         gap;
        logic [7:0] e_data;
        logic       e_rda;
        logic       e_oe;
        logic       e_fe;
        logic       e_rise;
    } vec_t;

    vec_t tbl [7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One clock: drive the read strobe for this edge, then sample outputs 1 time unit later.
    task automatic step();
        rx_enable = manual_read || (cyc + 1 == read_at_cyc);
        @(posedge clk);
        #1;
        rx_enable = 1'b0;
        cyc++;
        if (fe) begin
            fe_seen++;
            fe_cyc = cyc;
        end
        if (rda && !rda_prev) rda_rise_cyc = cyc;
        rda_prev = rda;
    endtask

    task automatic hold(input logic v, input int n);
        rx = v;
        repeat (n) step();
    endtask

    task automatic do_read();
        manual_read = 1'b1;
        step();
        manual_read = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop, input int stop_len,
                              input logic same_read);
        fe_seen      = 0;
        fe_cyc       = -1;
        rda_rise_cyc = -1;
        start_cyc    = cyc;
        read_at_cyc  = same_read ? cyc + FRAME_LAT : -1;
        hold(1'b0, 16);
        for (int i = 0; i < 8; i++) hold(d[i], 16);
        hold(stop, stop_len);
        read_at_cyc = -1;
        rx = 1'b1;
    endtask

    task automatic frame_and_check(input string tag, input logic [7:0] d, input logic stop,
                                   input int extra_low, input logic same_read,
                                   input logic rd_after, input int gap,
                                   input logic [7:0] e_data, input logic e_rda,
                                   input logic e_oe, input logic e_fe, input logic e_rise);
        send_frame(d, stop, 16 + extra_low, same_read);
        hold(1'b1, gap);
        check({tag, ".rx_data"}, 32'(rx_data), 32'(e_data));
        check({tag, ".rda"}, 32'(rda), 32'(e_rda));
        check({tag, ".oe"}, 32'(oe), 32'(e_oe));
        check({tag, ".fe_pulses"}, fe_seen, 32'(e_fe));
        if (e_rise) check({tag, ".rda_latency"}, rda_rise_cyc - start_cyc, FRAME_LAT);
        if (e_fe) check({tag, ".fe_latency"}, fe_cyc - start_cyc, FRAME_LAT);
        if (rd_after) begin
            do_read();
            check({tag, ".rda_after_read"}, 32'(rda), 32'd0);
            check({tag, ".oe_after_read"}, 32'(oe), 32'd0);
        end
    endtask

    initial begin
        //        d      stop xlow same rd  gap  e_data e_rda e_oe e_fe e_rise
        tbl[0] = '{8'hA5, 1'b1, 0,  1'b0, 1'b1, 20,  8'hA5, 1'b1, 1'b0, 1'b0, 1'b1};
        tbl[1] = '{8'h3C, 1'b0, 40, 1'b0, 1'b0, 170, 8'hA5, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[2] = '{8'h01, 1'b1, 0,  1'b0, 1'b1, 20,  8'h01, 1'b1, 1'b0, 1'b0, 1'b1};
        tbl[3] = '{8'h11, 1'b1, 0,  1'b0, 1'b0, 20,  8'h11, 1'b1, 1'b0, 1'b0, 1'b1};
        tbl[4] = '{8'h22, 1'b1, 0,  1'b0, 1'b1, 20,  8'h22, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[5] = '{8'h11, 1'b1, 0,  1'b0, 1'b0, 20,  8'h11, 1'b1, 1'b0, 1'b0, 1'b1};
        tbl[6] = '{8'h7E, 1'b1, 0,  1'b1, 1'b1, 20,  8'h7E, 1'b1, 1'b0, 1'b0, 1'b0};

        rx        = 1'b1;
        baud_tick = 1'b1;
        rx_enable = 1'b0;
        rst_n     = 1'b0;
        repeat (3) step();
        check("reset.rx_data", 32'(rx_data), 32'h00);
        check("reset.rda", 32'(rda), 32'd0);
        check("reset.fe", 32'(fe), 32'd0);
        check("reset.oe", 32'(oe), 32'd0);
        rst_n = 1'b1;
        hold(1'b1, 20);

        // Directed frames: good read, framing error with stuck-low line, overrun,
        // and a read landing on the same edge as a good stop bit.
        for (int i = 0; i < 7; i++) begin
            frame_and_check($sformatf("vec%0d", i), tbl[i].d, tbl[i].stop, tbl[i].extra_low,
                            tbl[i].same_read, tbl[i].rd_after, tbl[i].gap, tbl[i].e_data,
                            tbl[i].e_rda, tbl[i].e_oe, tbl[i].e_fe, tbl[i].e_rise);
        end

        // 4-tick low glitch on an idle line must not start a frame.
        fe_seen = 0;
        hold(1'b0, 4);
        hold(1'b1, 200);
        check("glitch.fe_pulses", fe_seen, 0);
        check("glitch.rda", 32'(rda), 32'd0);
        frame_and_check("after_glitch", 8'h3C, 1'b1, 0, 1'b0, 1'b0, 20,
                        8'h3C, 1'b1, 1'b0, 1'b0, 1'b1);
        frame_and_check("overrun", 8'h11, 1'b1, 0, 1'b0, 1'b0, 20,
                        8'h11, 1'b1, 1'b1, 1'b0, 1'b0);

        // Reset in the middle of the data bits of 0xFF.
        hold(1'b0, 16);
        hold(1'b1, 50);
        rst_n = 1'b0;
        #1;
        check("midreset.rx_data", 32'(rx_data), 32'h00);
        check("midreset.rda", 32'(rda), 32'd0);
        check("midreset.oe", 32'(oe), 32'd0);
        check("midreset.fe", 32'(fe), 32'd0);
        hold(1'b1, 3);
        rst_n = 1'b1;
        hold(1'b1, 20);
        check("postreset.rda", 32'(rda), 32'd0);
        frame_and_check("after_reset", 8'h5A, 1'b1, 0, 1'b0, 1'b0, 20,
                        8'h5A, 1'b1, 1'b0, 1'b0, 1'b1);

        // Without baud ticks the line is ignored, but a read still takes effect.
        fe_seen   = 0;
        baud_tick = 1'b0;
        hold(1'b0, 30);
        hold(1'b1, 5);
        baud_tick = 1'b1;
        hold(1'b1, 200);
        check("notick.fe_pulses", fe_seen, 0);
        check("notick.rx_data", 32'(rx_data), 32'h5A);
        check("notick.rda", 32'(rda), 32'd1);
        baud_tick = 1'b0;
        do_read();
        check("notick_read.rda", 32'(rda), 32'd0);
        baud_tick = 1'b1;
        hold(1'b1, 10);

        // Random frames against the character-level model.
        m_data = 8'h5A;
        m_rda  = 1'b0;
        m_oe   = 1'b0;
        for (int n = 0; n < 14; n++) begin
            logic [7:0] d;
            logic       stop;
            logic       same;
            logic       rd;
            logic       rise;
            int         xlow;
            int         gap;
            d    = 8'($urandom);
            stop = ($urandom_range(0, 3) != 0);
            xlow = stop ? 0 : int'($urandom_range(0, 30));
            same = stop && ($urandom_range(0, 3) == 0);
            rd   = 1'($urandom_range(0, 1));
            gap  = int'($urandom_range(16, 40));
            rise = stop && !m_rda;
            if (stop) begin
                m_oe   = same ? 1'b0 : (m_oe | m_rda);
                m_rda  = 1'b1;
                m_data = d;
            end
            frame_and_check($sformatf("rand%0d", n), d, stop, xlow, same, rd, gap,
                            m_data, m_rda, m_oe, !stop, rise);
            if (rd) begin
                m_rda = 1'b0;
                m_oe  = 1'b0;
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/spart_rx.md
# spart_rx

Serial receive stage of the SPART. It consumes the asynchronous RX line and the baud-generator oversample tick. It deframes 8N1 characters into a one-entry holding register, and presents `rx_data`/`rda` to the SPART bus interface. That interface returns `rx_enable` when the CPU reads the SPART data address.

## Interface
- `OVERSAMPLE`, default 16: baud ticks per bit; must be even and ≥ 4.
- `clk` in 1: system clock.
- `rst_n` in 1: reset, asynchronous and active-low.
- `rx` in 1: raw serial line, asynchronous to `clk`; idle high.
- `baud_tick` in 1: one-`clk` pulse from the baud generator at OVERSAMPLE × baud rate.
- `rx_enable` in 1: read strobe from the bus interface; consumes the held character.
- `rx_data` out 8: last good character received.
- `rda` out 1: receive data available.
- `fe` out 1: framing error; one-`clk` pulse.
- `oe` out 1: overrun; sticky, cleared by `rx_enable`.

## Operation
- `rx` passes through a 2-flop synchronizer (`rx_s`), which resets to 1. All FSM decisions use `rx_s`, and only on cycles where `baud_tick` = 1.
- Tick counter `cnt` has width $clog2(OVERSAMPLE). Bit counter `bits` is 3 bits wide.
- **IDLE**: when `rx_s`=0 on a tick, go to START with `cnt`=0.
- **START**: count ticks.
  - If `rx_s`=1 on any tick before `cnt` reaches OVERSAMPLE/2−1, treat it as a glitch and return to IDLE.
  - If `rx_s` is still 0 at `cnt`=OVERSAMPLE/2−1 (mid start bit), go to DATA with `cnt`=0 and `bits`=0.
- **DATA**: at `cnt`=OVERSAMPLE−1, shift `rx_s` into the shift register, LSB first.
  - After the 8th bit, go to STOP with `cnt`=0.
- **STOP**: sample at `cnt`=OVERSAMPLE−1.
  - Sample = 1: load `rx_data` from the shift register, set `rda`; if `rda` was already 1, set `oe`. Go to IDLE.
  - Sample = 0: pulse `fe`; leave `rx_data`, `rda` and `oe` unchanged; go to BREAK.
- **BREAK**: wait for `rx_s`=1 on a tick, then go to IDLE. This prevents a stuck-low line from re-triggering frames.
- `rx_enable` clears `rda` and `oe` on the next edge.
- If `rx_enable` and a good stop bit land in the same cycle, the load wins: `rda`=1, `rx_data` = new character, `oe`=0.
- `rx_data` is held stable while `rda`=1 unless it is overwritten by an overrun.

## Timing
- Reset values: `rx_data`=0x00, `rda`=0, `fe`=0, `oe`=0, state IDLE, counters 0, synchronizer flops 1.
- Reset mid-frame aborts the frame immediately. No partial data becomes visible.
- Synchronizer latency is 2 `clk` from `rx` to `rx_s`.
- `rda` rises on the `clk` edge after the stop-bit sampling tick. This is about 9.5 bit times after the start edge, plus up to 2 `clk` of sync latency and 1 tick of quantization.
- `fe` is high for exactly one `clk`, on the same edge where a good stop bit would have set `rda`.
- `rx_enable` effects are visible one `clk` after it is asserted. `rx_enable` while `rda`=0 is harmless.
- Non-tick cycles change nothing except `rx_enable` handling and `fe` deassertion.

## Structure
- Shared package `spart_pkg`:
  - state enum `rx_state_t` (IDLE, START, DATA, STOP, BREAK);
  - `SPART_OVERSAMPLE` = 16;
  - the SPART I/O address constants (DATA=2'b00, STATUS=2'b01, DIV_LOW=2'b10, DIV_HIGH=2'b11), shared with the bus interface and the baud generator.
- One sub-module, `sync_2ff`: 1-bit two-flop synchronizer with async active-low reset and a reset-value parameter. It is instantiated here and reusable for other asynchronous inputs.

## Test plan
All scenarios use OVERSAMPLE=16 and `baud_tick` every `clk` (16 `clk` per bit).
- Frame 0xA5, 8N1 → `rda` rises about 152 `clk` after the start edge; `rx_data`=0xA5, `fe`=0, `oe`=0. Then `rx_enable` → `rda`=0 next cycle.
- 4-tick low glitch on an idle line → FSM returns to IDLE; `rda` and `fe` stay 0. A following frame 0x3C is received correctly.
- Frame 0x3C with stop bit 0, line held low 40 ticks → `fe` pulses once, `rda`=0, FSM stays in BREAK until the line goes high. The next frame 0x01 is received.
- Frames 0x11 then 0x22 with no read between them → `rx_data`=0x22, `rda`=1, `oe`=1. Then `rx_enable` → `rda`=0, `oe`=0.
- `rx_enable` asserted on the same cycle the stop bit of 0x7E is accepted, with 0x11 previously pending → `rda`=1, `rx_data`=0x7E, `oe`=0.
- `rst_n` asserted mid-DATA of 0xFF, released, then frame 0x5A sent → all outputs read reset values during reset; 0x5A is received cleanly with no corruption from the aborted frame.
